// File: rtl/pc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_ctrl_pkg
//  Description : Shared constants for the fetch program-counter controller:
//                FSM state encoding, default reset PC, instruction size.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_ctrl_pkg;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    // FSM state encoding
    localparam logic [1:0]  ST_BOOT  = 2'd0;
    localparam logic [1:0]  ST_FETCH = 2'd1;
    localparam logic [1:0]  ST_DRAIN = 2'd2;
    localparam logic [1:0]  ST_HOLD  = 2'd3;

endpackage : pc_ctrl_pkg
`default_nettype wire

// File: rtl/pc_ctrl_npc.sv
`default_nettype none
// ============================================================================
//  Module      : npc
//  Description : Combinational next-PC adder. Jumps produce pc+imm (bit 0
//                cleared for jalr); otherwise pc+INSTR_BYTES. Wraps mod 2^XLEN.
//  Revision    : 1.0 - initial release
// ============================================================================
module npc
    import pc_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            is_jump_i,
    input  logic            is_jalr_i,
    input  logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] npc_o
);

    logic [XLEN-1:0] w_sum;

    // Add offset (imm or instruction size); jalr targets drop bit 0 only
    always_comb begin
        w_sum = pc_i + (is_jump_i ? imm_i : XLEN'(INSTR_BYTES));
        npc_o = w_sum;
        if (is_jump_i && is_jalr_i) begin
            npc_o[0] = 1'b0;
        end
    end

endmodule : npc
`default_nettype wire

// File: rtl/pc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pc_ctrl
//  Description : Instruction-fetch PC controller. Issues fetch requests,
//                qualifies responses, and handles branch redirects that may
//                arrive while a request is still outstanding.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic            redirect_is_jalr_i,
    input  logic [XLEN-1:0] redirect_base_i,
    input  logic [XLEN-1:0] redirect_imm_i,
    output logic            if_req_o,
    output logic [XLEN-1:0] if_addr_o,
    input  logic            if_ack_i,
    output logic            fetch_valid_o,
    output logic [XLEN-1:0] fetch_pc_o,
    output logic            squash_o
);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pending_q, pending_d;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_seq_pc;
    logic [1:0]      w_after_ack;

    // Redirect target: base + imm
    npc #(.XLEN(XLEN)) u_npc_target (
        .pc_i      (redirect_base_i),
        .is_jump_i (1'b1),
        .is_jalr_i (redirect_is_jalr_i),
        .imm_i     (redirect_imm_i),
        .npc_o     (w_target)
    );

    // Sequential successor: pc + 4
    npc #(.XLEN(XLEN)) u_npc_seq (
        .pc_i      (pc_q),
        .is_jump_i (1'b0),
        .is_jalr_i (1'b0),
        .imm_i     ('0),
        .npc_o     (w_seq_pc)
    );

    // Where to go once the outstanding request is acknowledged
    assign w_after_ack = stall_i ? ST_HOLD : ST_FETCH;

    // Next-state, PC and pending-target selection
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pending_d = pending_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
                pc_d    = RESET_PC;
            end
            ST_FETCH: begin
                if (redirect_valid_i) begin
                    if (if_ack_i) begin
                        pc_d    = w_target;
                        state_d = w_after_ack;
                    end else begin
                        // Request still in flight: remember target, keep address
                        pending_d = w_target;
                        state_d   = ST_DRAIN;
                    end
                end else if (if_ack_i) begin
                    pc_d    = w_seq_pc;
                    state_d = w_after_ack;
                end
            end
            ST_DRAIN: begin
                if (if_ack_i) begin
                    pc_d    = redirect_valid_i ? w_target : pending_q;
                    state_d = w_after_ack;
                end else if (redirect_valid_i) begin
                    pending_d = w_target;
                end
            end
            ST_HOLD: begin
                if (redirect_valid_i) begin
                    pc_d = w_target;
                end
                if (!stall_i) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
        end
    end

    // Outputs decoded from state; BOOT during reset suppresses every pulse
    always_comb begin
        if_req_o      = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
        if_addr_o     = pc_q;
        fetch_valid_o = (state_q == ST_FETCH) && if_ack_i && !redirect_valid_i;
        squash_o      = if_ack_i && (((state_q == ST_FETCH) && redirect_valid_i) ||
                                     (state_q == ST_DRAIN));
        fetch_pc_o    = fetch_valid_o ? pc_q : '0;
    end

endmodule : pc_ctrl
`default_nettype wire
